frame_renderer: RTL and testbench

Raster scanner between the combinational graphics stage and the LT24 display controller. On each frame request it walks every pixel of the LCD in row-major order: it presents a coordinate to the graphics stage, captures the returned RGB565 colour and writes it to the display through the `pixelWrite`/`pixelReady` handshake. It reports frame progress so the game logic can avoid updating ball and paddle state mid-frame.

---
 rtl/frame_renderer.sv | 117 +++++++++++
 tb/tb_frame_renderer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_renderer.sv
// Raster scanner: walks every LCD pixel in row-major order, fetching colour from graphics and writing it to the LT24.
// Optional build macro RENDER_FREE_RUN_EN makes scanning continuous and ignores frame_start.
module frame_renderer #(
  parameter int WIDTH  = 240,
  parameter int HEIGHT = 320,
  parameter int XW     = 8,
  parameter int YW     = 9
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          frame_start,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  input  logic [15:0]   pixel_rgb,
  output logic [XW-1:0] xAddr,
  output logic [YW-1:0] yAddr,
  output logic [15:0]   pixelData,
  output logic          pixelWrite,
  input  logic          pixelReady,
  output logic          frame_busy,
  output logic          frame_done,
  output logic [7:0]    frame_count
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} stateT;

  stateT         state_q, state_d;
  logic [XW-1:0] cx_q, cx_d, xAddr_q, xAddr_d;
  logic [YW-1:0] cy_q, cy_d, yAddr_q, yAddr_d;
  logic [15:0]   pixelData_q, pixelData_d;
  logic [7:0]    frameCount_q, frameCount_d;
  logic          startReq;

`ifdef RENDER_FREE_RUN_EN
  // Free-running: the request input is referenced but has no effect.
  assign startReq = frame_start | 1'b1;
`else
  assign startReq = frame_start;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      xAddr_q      <= '0;
      yAddr_q      <= '0;
      pixelData_q  <= '0;
      frameCount_q <= '0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      xAddr_q      <= xAddr_d;
      yAddr_q      <= yAddr_d;
      pixelData_q  <= pixelData_d;
      frameCount_q <= frameCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    xAddr_d      = xAddr_q;
    yAddr_d      = yAddr_q;
    pixelData_d  = pixelData_q;
    frameCount_d = frameCount_q;
    case (state_q)
      IDLE: begin
        cx_d = '0;
        cy_d = '0;
        if (startReq) state_d = FETCH;
      end
      FETCH: begin
        pixelData_d = pixel_rgb;
        xAddr_d     = cx_q;
        yAddr_d     = cy_q;
        state_d     = WRITE;
      end
      WRITE: begin
        // The last pixel clears both counters so they never pass HEIGHT-1.
        if (pixelReady) begin
          if (cx_q == XW'(WIDTH - 1)) begin
            cx_d = '0;
            if (cy_q == YW'(HEIGHT - 1)) begin
              cy_d    = '0;
              state_d = DONE;
            end else begin
              cy_d    = cy_q + YW'(1);
              state_d = FETCH;
            end
          end else begin
            cx_d    = cx_q + XW'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        frameCount_d = frameCount_q + 8'd1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pixel_x     = cx_q;
  assign pixel_y     = cy_q;
  assign xAddr       = xAddr_q;
  assign yAddr       = yAddr_q;
  assign pixelData   = pixelData_q;
  assign pixelWrite  = (state_q == WRITE);
  assign frame_busy  = (state_q == FETCH) || (state_q == WRITE);
  assign frame_done  = (state_q == DONE);
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer on a 4x3 panel; graphics returns {y,x} as colour.
// Build with RENDER_FREE_RUN_EN defined to exercise the free-running sequence instead.
module tb_frame_renderer;

  localparam int W = 4;
  localparam int H = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        pixelReady = 1'b1;
  logic [7:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic [15:0] pixel_rgb;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite;
  logic        frame_busy;
  logic        frame_done;
  logic [7:0]  frame_count;

  int total = 0;
  int bad = 0;
  int xferCount = 0;

  frame_renderer #(.WIDTH(W), .HEIGHT(H), .XW(8), .YW(9)) dut (
    .clock(clock), .reset(reset), .frame_start(frame_start),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData),
    .pixelWrite(pixelWrite), .pixelReady(pixelReady),
    .frame_busy(frame_busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  assign pixel_rgb = {pixel_y[7:0], pixel_x};

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pixelWrite && pixelReady) xferCount <= xferCount + 1;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic checkIdleReset();
    checkOutput("rstWrite", pixelWrite, 0);
    checkOutput("rstBusy", frame_busy, 0);
    checkOutput("rstDone", frame_done, 0);
    checkOutput("rstCount", frame_count, 0);
    checkOutput("rstPixX", pixel_x, 0);
    checkOutput("rstPixY", pixel_y, 0);
    checkOutput("rstXAddr", xAddr, 0);
    checkOutput("rstYAddr", yAddr, 0);
    checkOutput("rstData", pixelData, 0);
  endtask

  // Called in the first FETCH cycle; walks the frame with per-pixel checks.
  task automatic runFrame(input int stallPixel, input int ignorePixel, input int resetPixel);
    int startXfer;
    int pre;
    int ex;
    int ey;
    logic [15:0] expData;
    startXfer = xferCount;
    for (int p = 0; p < W * H; p++) begin
      ex = p % W;
      ey = p / W;
      expData = {ey[7:0], ex[7:0]};
      checkOutput("fetchBusy", frame_busy, 1);
      checkOutput("fetchWrite", pixelWrite, 0);
      checkOutput("fetchPixX", pixel_x, ex);
      checkOutput("fetchPixY", pixel_y, ey);
      if (p == ignorePixel) frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      checkOutput("writeReq", pixelWrite, 1);
      checkOutput("writeXAddr", xAddr, ex);
      checkOutput("writeYAddr", yAddr, ey);
      checkOutput("writeData", pixelData, expData);
      if (p == resetPixel) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkIdleReset();
        return;
      end
      if (p == stallPixel) begin
        pixelReady = 1'b0;
        for (int s = 0; s < 5; s++) begin
          tick();
          checkOutput("stallWrite", pixelWrite, 1);
          checkOutput("stallXAddr", xAddr, ex);
          checkOutput("stallYAddr", yAddr, ey);
          checkOutput("stallData", pixelData, expData);
          checkOutput("stallPixX", pixel_x, ex);
        end
        pre = xferCount;
        pixelReady = 1'b1;
        tick();
        checkOutput("stallOneXfer", xferCount, pre + 1);
        checkOutput("stallDrop", pixelWrite, 0);
      end else begin
        tick();
      end
    end
    checkOutput("doneAfter2WH", frame_done, 1);
    checkOutput("doneBusy", frame_busy, 0);
    checkOutput("doneWrite", pixelWrite, 0);
    checkOutput("frameXfers", xferCount - startXfer, W * H);
    tick();
    checkOutput("idleDone", frame_done, 0);
    checkOutput("idleBusy", frame_busy, 0);
  endtask

  task automatic waitDone(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 2 * W * H + 10; c++) begin
      tick();
      if (frame_done) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, seen, 1);
  endtask

  initial begin
    tick();
    tick();
    checkIdleReset();
    reset = 1'b0;
`ifdef RENDER_FREE_RUN_EN
    tick();
    checkOutput("frFetch", frame_busy, 1);
    checkOutput("frPixX", pixel_x, 0);
    tick();
    checkOutput("frWrite", pixelWrite, 1);
    waitDone("frFirstDone");
    tick();
    checkOutput("frIdleBusy", frame_busy, 0);
    checkOutput("frCount", frame_count, 1);
    tick();
    checkOutput("frRestartBusy", frame_busy, 1);
    checkOutput("frRestartX", pixel_x, 0);
    checkOutput("frRestartY", pixel_y, 0);
    tick();
    checkOutput("frRestartWrite", pixelWrite, 1);
    checkOutput("frRestartXAddr", xAddr, 0);
    checkOutput("frRestartYAddr", yAddr, 0);
`else
    tick();
    checkOutput("idleNoStart", frame_busy, 0);

    $display("[TB] full frame");
    applyStimulus();
    runFrame(-1, -1, -1);
    checkOutput("countOne", frame_count, 1);

    $display("[TB] backpressure on (2,1) and ignored request");
    applyStimulus();
    runFrame(6, 1, -1);
    checkOutput("countTwo", frame_count, 2);
    checkOutput("totalXfers", xferCount, 2 * W * H);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stayIdle", frame_busy, 0);
    end

    $display("[TB] reset mid-frame at (1,1)");
    applyStimulus();
    runFrame(-1, -1, 5);
    tick();
    checkOutput("postRstIdle", frame_busy, 0);
    applyStimulus();
    runFrame(-1, -1, -1);
    checkOutput("countAfterRst", frame_count, 1);

    $display("[TB] counter wrap");
    for (int f = 1; f < 255; f++) begin
      applyStimulus();
      waitDone("wrapDone");
      tick();
    end
    checkOutput("count255", frame_count, 255);
    applyStimulus();
    waitDone("wrapDone");
    tick();
    checkOutput("countWrap0", frame_count, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
